// File: rtl/timed_cmd_queue_if.sv
// Write and dispatch handshakes of timed_cmd_queue.
// The master side writes timed commands and consumes dispatched ones; the queue is the slave.
interface timed_cmd_queue_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned TW = 64,
    parameter int unsigned PW = 274
);
    logic          WR;
    logic [TW-1:0] WR_TIME;
    logic [PW-1:0] WR_DATA;
    logic          WR_ACK;
    logic          WR_ERR;
    logic          CMD_VALID;
    logic          CMD_READY;
    logic [TW-1:0] CMD_TIME;
    logic [PW-1:0] CMD_DATA;
    logic [AW-1:0] CMD_ADDR;

    modport master (
        output WR, WR_TIME, WR_DATA, CMD_READY,
        input  WR_ACK, WR_ERR, CMD_VALID, CMD_TIME, CMD_DATA, CMD_ADDR
    );

    modport slave (
        input  WR, WR_TIME, WR_DATA, CMD_READY,
        output WR_ACK, WR_ERR, CMD_VALID, CMD_TIME, CMD_DATA, CMD_ADDR
    );
endinterface

// File: rtl/timed_cmd_queue.sv
// DEPTH-entry timed-command store with a round-robin scanner that dispatches due commands.
// Optional TCQ_EXPIRE_DROP_EN: scanner invalidates expired entries and counts them in DROP_CNT.
module timed_cmd_queue #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned AW          = $clog2(DEPTH),
    parameter int unsigned TW          = 64,
    parameter int unsigned PW          = 274,
    parameter int unsigned TIME_REZERV = 384
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic [TW-1:0]         TIME,
    input  logic                  CLR_ALL,
    timed_cmd_queue_if.slave      bus,
    output logic [AW:0]           COUNT,
    output logic                  FULL,
    output logic [15:0]           DROP_CNT
);
    typedef enum logic [1:0] {IDLE, SCAN, HOLD, RETIRE} state_t;

    localparam logic [TW:0] REZERV = (TW+1)'(TIME_REZERV);

    state_t              state_q, state_d;
    logic [TW+PW-1:0]    mem [DEPTH];
    logic [TW+PW-1:0]    rd_q;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [AW:0]         count_q, count_d;
    logic [AW-1:0]       ptr_q, rd_addr_q, wr_idx;
    logic                rd_pend_q, rd_stale_q;
    logic [TW-1:0]       cmd_time_q;
    logic [PW-1:0]       cmd_data_q;
    logic [AW-1:0]       cmd_addr_q;
    logic                wr_ack_q, wr_err_q;
    logic                wr_ok, retire, scan_on, cmp_live, is_due, hit, drop;
    logic [TW:0]         t_ext, now_ext;

    assign FULL    = (count_q == (AW+1)'(DEPTH));
    assign COUNT   = count_q;
    assign wr_ok   = bus.WR && !CLR_ALL && !FULL;

    // Lowest free index wins: scan high to low so the last assignment is the lowest.
    always_comb begin
        wr_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!valid_q[DEPTH-1-i]) wr_idx = AW'(DEPTH-1-i);
        end
    end

    assign t_ext    = {1'b0, rd_q[TW+PW-1:PW]};
    assign now_ext  = {1'b0, TIME};
    assign is_due   = (now_ext < t_ext) && (t_ext <= now_ext + REZERV);
    // A read that raced a write into the same slot returns stale data; skip it this pass.
    assign cmp_live = rd_pend_q && !rd_stale_q && valid_q[rd_addr_q];
    assign hit      = cmp_live && is_due;

`ifdef TCQ_EXPIRE_DROP_EN
    logic [15:0] drop_cnt_q;
    assign drop     = cmp_live && (t_ext <= now_ext) && !CLR_ALL;
    assign DROP_CNT = drop_cnt_q;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (drop && drop_cnt_q != '1) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end
`else
    assign drop     = 1'b0;
    assign DROP_CNT = '0;
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = SCAN;
            SCAN: begin
                if (hit)                 state_d = HOLD;
                else if (count_q == '0)  state_d = IDLE;
            end
            HOLD:    if (bus.CMD_READY) state_d = RETIRE;
            RETIRE: begin
                retire  = 1'b1;
                state_d = SCAN;
            end
            default: state_d = IDLE;
        endcase
        if (CLR_ALL) begin
            state_d = IDLE;
            retire  = 1'b0;
        end
    end

    assign scan_on = (state_q == SCAN) && (state_d == SCAN);

    always_comb begin
        valid_d = valid_q;
        if (wr_ok)   valid_d[wr_idx]     = 1'b1;
        if (retire)  valid_d[cmd_addr_q] = 1'b0;
        if (drop)    valid_d[rd_addr_q]  = 1'b0;
        if (CLR_ALL) valid_d             = '0;
        count_d = count_q + (AW+1)'(wr_ok) - (AW+1)'(retire) - (AW+1)'(drop);
        if (CLR_ALL) count_d = '0;
    end

    always_ff @(posedge CLK) begin
        if (wr_ok) mem[wr_idx] <= {bus.WR_TIME, bus.WR_DATA};
        rd_q <= mem[ptr_q];
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            count_q    <= '0;
            ptr_q      <= '0;
            rd_addr_q  <= '0;
            rd_pend_q  <= 1'b0;
            rd_stale_q <= 1'b0;
            cmd_time_q <= '0;
            cmd_data_q <= '0;
            cmd_addr_q <= '0;
            wr_ack_q   <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            count_q    <= count_d;
            wr_ack_q   <= wr_ok;
            wr_err_q   <= bus.WR && !CLR_ALL && FULL;
            rd_pend_q  <= scan_on;
            rd_addr_q  <= ptr_q;
            rd_stale_q <= wr_ok && (wr_idx == ptr_q);
            if (scan_on)     ptr_q <= ptr_q + AW'(1);
            else if (retire) ptr_q <= cmd_addr_q + AW'(1);
            if (state_q == SCAN && state_d == HOLD) begin
                cmd_time_q <= rd_q[TW+PW-1:PW];
                cmd_data_q <= rd_q[PW-1:0];
                cmd_addr_q <= rd_addr_q;
            end
        end
    end

    assign bus.CMD_VALID = (state_q == HOLD);
    assign bus.CMD_TIME  = cmd_time_q;
    assign bus.CMD_DATA  = cmd_data_q;
    assign bus.CMD_ADDR  = cmd_addr_q;
    assign bus.WR_ACK    = wr_ack_q;
    assign bus.WR_ERR    = wr_err_q;
endmodule

// File: tb/tb_timed_cmd_queue.sv
// Directed bench for timed_cmd_queue: table-driven write vectors plus hand-written
// dispatch, fill/overflow, round-robin, clear and expiry sequences.
module tb_timed_cmd_queue;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;
    localparam int unsigned TW    = 64;
    localparam int unsigned PW    = 274;

    logic          CLK = 1'b0;
    logic          rst_n = 1'b0;
    logic [TW-1:0] TIME = '0;
    logic          CLR_ALL = 1'b0;
    logic [AW:0]   COUNT;
    logic          FULL;
    logic [15:0]   DROP_CNT;

    int checks = 0;
    int failures = 0;

    timed_cmd_queue_if #(.AW(AW), .TW(TW), .PW(PW)) bus ();

    timed_cmd_queue #(
        .DEPTH(DEPTH), .AW(AW), .TW(TW), .PW(PW), .TIME_REZERV(384)
    ) dut (
        .CLK(CLK), .rst_n(rst_n), .TIME(TIME), .CLR_ALL(CLR_ALL),
        .bus(bus), .COUNT(COUNT), .FULL(FULL), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          wr;
        logic [TW-1:0] wtime;
        logic          exp_ack;
        logic          exp_err;
        logic [AW:0]   exp_count;
        logic          exp_valid;
    } vec_t;

    function automatic logic [PW-1:0] mkdata(input logic [TW-1:0] t);
        return {18'h2A5A5, t, ~t, t ^ 64'h0123456789ABCDEF, t + 64'd17};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int unsigned budget, input string name);
        int unsigned n = 0;
        while (bus.CMD_VALID !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(name, 384'(bus.CMD_VALID), 384'(1));
    endtask

    task automatic write(input logic [TW-1:0] t);
        bus.WR      = 1'b1;
        bus.WR_TIME = t;
        bus.WR_DATA = mkdata(t);
        tick();
        bus.WR      = 1'b0;
    endtask

    task automatic accept();
        bus.CMD_READY = 1'b1;
        tick();
        bus.CMD_READY = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, 384'(bus.CMD_VALID), 384'(0));
        chk({tag, "_time"},  384'(bus.CMD_TIME),  384'(0));
        chk({tag, "_data"},  384'(bus.CMD_DATA),  384'(0));
        chk({tag, "_addr"},  384'(bus.CMD_ADDR),  384'(0));
        chk({tag, "_ack"},   384'(bus.WR_ACK),    384'(0));
        chk({tag, "_err"},   384'(bus.WR_ERR),    384'(0));
        chk({tag, "_count"}, 384'(COUNT),         384'(0));
        chk({tag, "_full"},  384'(FULL),          384'(0));
        chk({tag, "_drop"},  384'(DROP_CNT),      384'(0));
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{1'b1, 64'd1000, 1'b1, 1'b0, 9'd1, 1'b0};
        vecs[1] = '{1'b1, 64'd2000, 1'b1, 1'b0, 9'd2, 1'b0};
        vecs[2] = '{1'b1, 64'd3000, 1'b1, 1'b0, 9'd3, 1'b0};
        vecs[3] = '{1'b0, 64'd0,    1'b0, 1'b0, 9'd3, 1'b0};
        vecs[4] = '{1'b0, 64'd0,    1'b0, 1'b0, 9'd3, 1'b0};

        bus.WR = 1'b0; bus.WR_TIME = '0; bus.WR_DATA = '0; bus.CMD_READY = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();

        // Three writes at TIME=0, nothing due yet
        for (int i = 0; i < 5; i++) begin
            bus.WR      = vecs[i].wr;
            bus.WR_TIME = vecs[i].wtime;
            bus.WR_DATA = mkdata(vecs[i].wtime);
            tick();
            chk($sformatf("vec%0d_ack", i),   384'(bus.WR_ACK),    384'(vecs[i].exp_ack));
            chk($sformatf("vec%0d_err", i),   384'(bus.WR_ERR),    384'(vecs[i].exp_err));
            chk($sformatf("vec%0d_count", i), 384'(COUNT),         384'(vecs[i].exp_count));
            chk($sformatf("vec%0d_valid", i), 384'(bus.CMD_VALID), 384'(vecs[i].exp_valid));
        end
        bus.WR = 1'b0;

        // First dispatch: 1000 becomes due at TIME=700
        TIME = 64'd700;
        wait_valid(DEPTH + 2, "first_due");
        chk("first_time", 384'(bus.CMD_TIME), 384'(1000));
        chk("first_addr", 384'(bus.CMD_ADDR), 384'(0));
        chk("first_data", 384'(bus.CMD_DATA), 384'(mkdata(64'd1000)));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", 384'(bus.CMD_VALID), 384'(1));
            chk("hold_time",  384'(bus.CMD_TIME),  384'(1000));
            chk("hold_addr",  384'(bus.CMD_ADDR),  384'(0));
        end
        accept();
        chk("retire_valid", 384'(bus.CMD_VALID), 384'(0));
        tick();
        chk("retire_count", 384'(COUNT), 384'(2));

        // Index 1 holds 2000
        TIME = 64'd1700;
        wait_valid(DEPTH + 2, "second_due");
        chk("second_time", 384'(bus.CMD_TIME), 384'(2000));
        chk("second_addr", 384'(bus.CMD_ADDR), 384'(1));

        // Clear during HOLD with a simultaneous write that would otherwise be acked
        CLR_ALL = 1'b1;
        write(64'd5000);
        CLR_ALL = 1'b0;
        chk("clr1_valid", 384'(bus.CMD_VALID), 384'(0));
        chk("clr1_count", 384'(COUNT),         384'(0));
        chk("clr1_ack",   384'(bus.WR_ACK),    384'(0));
        chk("clr1_err",   384'(bus.WR_ERR),    384'(0));
        tick();
        chk("clr1_ack_after", 384'(bus.WR_ACK), 384'(0));
        chk("clr1_count_after", 384'(COUNT),    384'(0));

        // Fill all entries; only index 7 is due
        for (int unsigned i = 0; i < DEPTH; i++) begin
            write((i == 7) ? 64'd1800 : 64'(200000 + i));
            chk("fill_ack", 384'(bus.WR_ACK), 384'(1));
        end
        chk("fill_count", 384'(COUNT), 384'(256));
        chk("fill_full",  384'(FULL),  384'(1));
        write(64'd1900);
        chk("ovf_err",   384'(bus.WR_ERR), 384'(1));
        chk("ovf_ack",   384'(bus.WR_ACK), 384'(0));
        chk("ovf_count", 384'(COUNT),      384'(256));
        chk("ovf_full",  384'(FULL),       384'(1));
        tick();
        chk("ovf_err_pulse", 384'(bus.WR_ERR), 384'(0));
        wait_valid(DEPTH + 2, "full_due");
        chk("full_addr", 384'(bus.CMD_ADDR), 384'(7));
        chk("full_time", 384'(bus.CMD_TIME), 384'(1800));
        accept();
        tick();
        chk("free_count", 384'(COUNT), 384'(255));
        chk("free_full",  384'(FULL),  384'(0));
        write(64'd1850);
        chk("reuse_ack",   384'(bus.WR_ACK), 384'(1));
        chk("reuse_count", 384'(COUNT),      384'(256));
        wait_valid(DEPTH + 2, "reuse_due");
        chk("reuse_addr", 384'(bus.CMD_ADDR), 384'(7));
        chk("reuse_time", 384'(bus.CMD_TIME), 384'(1850));
        chk("reuse_data", 384'(bus.CMD_DATA), 384'(mkdata(64'd1850)));

        // Clear during HOLD while FULL: the simultaneous write gets no ERR either
        CLR_ALL = 1'b1;
        write(64'd1900);
        CLR_ALL = 1'b0;
        chk("clr2_valid", 384'(bus.CMD_VALID), 384'(0));
        chk("clr2_count", 384'(COUNT),         384'(0));
        chk("clr2_err",   384'(bus.WR_ERR),    384'(0));
        chk("clr2_ack",   384'(bus.WR_ACK),    384'(0));

        // Round robin: index 5 due first, index 9 becomes due while 5 is held
        for (int unsigned i = 0; i < 10; i++) begin
            write((i == 5) ? 64'd2200 : (i == 9) ? 64'd2300 : 64'(200000 + i));
        end
        TIME = 64'd1900;
        wait_valid(DEPTH + 2, "rr_first");
        chk("rr_first_addr", 384'(bus.CMD_ADDR), 384'(5));
        TIME = 64'd2000;
        tick();
        chk("rr_hold_addr", 384'(bus.CMD_ADDR), 384'(5));
        accept();
        tick();
        chk("rr_retire_count", 384'(COUNT), 384'(9));
        chk("rr_retire_valid", 384'(bus.CMD_VALID), 384'(0));
        wait_valid(5, "rr_second_latency");
        chk("rr_second_addr", 384'(bus.CMD_ADDR), 384'(9));
        chk("rr_second_time", 384'(bus.CMD_TIME), 384'(2300));
        accept();
        tick();
        chk("rr_end_count", 384'(COUNT), 384'(8));

        // Mid-operation reset, then the expiry case
        rst_n = 1'b0;
        #2;
        check_reset_values("reset2");
        rst_n = 1'b1;
        TIME = 64'd100;
        tick();
        write(64'd50);
        chk("exp_ack",   384'(bus.WR_ACK), 384'(1));
        chk("exp_count", 384'(COUNT),      384'(1));
`ifdef TCQ_EXPIRE_DROP_EN
        for (int i = 0; i < int'(DEPTH) + 2 && COUNT != 0; i++) tick();
        chk("drop_count", 384'(COUNT),    384'(0));
        chk("drop_cnt",   384'(DROP_CNT), 384'(1));
`else
        repeat (DEPTH + 2) tick();
        chk("keep_count", 384'(COUNT),    384'(1));
        chk("keep_drop",  384'(DROP_CNT), 384'(0));
`endif
        chk("exp_valid", 384'(bus.CMD_VALID), 384'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
